pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the RV32I core.
- Generates hold/flush controls for the PC, if_id and id_ex registers, and redirects the PC on jump/branch.
- Handles four conditions: boot hold after reset, load-use hazards against the decode stage's rs1/rs2 addresses, data-bus wait stalls with timeout, and multi-cycle flush for the synchronous instruction ROM.
- Also keeps saturating stall/flush performance counters.

Parameters:
- BOOT_CYCLES, 4: cycles after reset release during which fetch is held and both stage registers are flushed.
- FLUSH_CYCLES, 1: extra cycles of if_id flush after a jump, covering instruction ROM read latency.
- BUS_TIMEOUT, 16: consecutive unacknowledged bus cycles before stall release and error.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- jump_en_in  input  1  ex stage resolves a taken jump/branch
- jump_addr_in  input  32  jump target from ex
- ex_load_in  input  1  instruction in ex is a load
- ex_rd_addr_in  input  5  destination register of the ex instruction
- rs1_addr_in  input  5  decode rs1 address (0 = unused)
- rs2_addr_in  input  5  decode rs2 address (0 = unused)
- bus_req_in  input  1  mem stage data-bus request pending
- bus_ack_in  input  1  data-bus acknowledge
- pc_hold_out  output  1  PC register keeps its value
- if_id_hold_out  output  1  if_id register keeps its value
- if_id_flush_out  output  1  if_id register loads NOP (0x00000013)
- id_ex_hold_out  output  1  id_ex register keeps its value
- id_ex_flush_out  output  1  id_ex register loads bubble (reg_enable=0)
- pc_jump_en_out  output  1  PC loads pc_jump_addr_out
- pc_jump_addr_out  output  32  redirect target
- boot_busy_out  output  1  high while in BOOT
- bus_err_out  output  1  sticky bus timeout flag
- stall_cnt_out  output  32  saturating count of stall cycles
- flush_cnt_out  output  32  saturating count of jump-flush events

Behaviour:
- FSM states: BOOT, RUN, BUS_WAIT, FLUSH. State, counters and bus_err_out are registered. Control outputs are combinational from the current state and inputs, so they take effect in the same cycle.
- Reset (async, rst_n=0):
  - state=BOOT, boot/flush/timeout counters=0, bus_err_out=0, stall_cnt_out=flush_cnt_out=0.
  - While in reset: pc_hold_out=1, if_id_flush_out=1, id_ex_flush_out=1, boot_busy_out=1, all other control outputs 0, pc_jump_addr_out=0.
  - Reset mid-operation abandons any flush or bus wait immediately.
- BOOT:
  - Outputs same as in reset; all other inputs are ignored.
  - After exactly BOOT_CYCLES rising edges with rst_n=1, go to RUN.
- Priority in RUN and FLUSH: bus wait > jump > load-use.
- Bus wait, when bus_req_in=1 and bus_ack_in=0:
  - pc_hold_out, if_id_hold_out and id_ex_hold_out =1; no flush; pc_jump_en_out suppressed.
  - Go to BUS_WAIT; stall_cnt increments.
- BUS_WAIT:
  - Holds stay asserted while bus_ack_in=0; the timeout counter increments each cycle.
  - On bus_ack_in=1 (or bus_req_in dropping): holds deassert that cycle, return to the previous RUN/FLUSH context.
  - If the counter reaches BUS_TIMEOUT with no ack: set bus_err_out=1 (held until reset), release holds, return to RUN, clear the counter.
- Jump (jump_en_in=1, no bus wait):
  - Same cycle: pc_jump_en_out=1, pc_jump_addr_out=jump_addr_in, if_id_flush_out=1, id_ex_flush_out=1.
  - Latch jump_addr_in; flush_cnt increments; go to FLUSH with counter=FLUSH_CYCLES.
- FLUSH:
  - if_id_flush_out=1 each cycle and the counter decrements; return to RUN when it reaches 0.
  - A new jump_en_in in FLUSH restarts the jump sequence and reloads the counter.
  - pc_jump_addr_out keeps the latched target outside jump cycles.
- Load-use, in RUN, no jump, no bus wait:
  - Condition: ex_load_in=1, ex_rd_addr_in≠0, and ex_rd_addr_in equals a nonzero rs1_addr_in or rs2_addr_in.
  - Response: pc_hold_out=1, if_id_hold_out=1, id_ex_flush_out=1 for that cycle; stall_cnt increments.
  - The condition clears naturally next cycle, so the stall lasts one cycle per hazard.
- x0 never causes a hazard.
- Counters saturate at 0xFFFFFFFF; no wrap.
- hold and flush are never both asserted on the same stage register.

Test Plan:
- Reset release -> boot_busy_out=1 and pc_hold_out=1 for 4 cycles, then 0; all flushes drop; counters 0.
- Load x5 in ex (ex_load_in=1, ex_rd_addr_in=5), decode rs2=5 -> exactly one cycle of pc_hold/if_id_hold/id_ex_flush; stall_cnt_out=1.
- Same with rs1=rs2=0 and ex_rd_addr_in=0 -> no stall.
- jump_en_in=1, jump_addr_in=0x00000100 -> same cycle: pc_jump_en_out=1, addr=0x100, both flushes. Next cycle: if_id_flush_out=1 only. Then RUN; flush_cnt_out=1.
- bus_req_in=1 with ack after 3 cycles, jump_en_in=1 concurrently -> 3 hold cycles with pc_jump_en_out=0, then jump taken on the release cycle; stall_cnt_out=3.
- bus_req_in=1 with no ack -> holds for 16 cycles, then bus_err_out=1 and holds released; assert rst_n=0 mid-FLUSH -> immediate BOOT outputs and bus_err_out=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the RV32I pipeline and its sequencing controller.
// The pipeline is the master: it drives the hazard/bus status and receives the hold/flush controls.
interface pipe_ctrl_if;
    logic        jump_en_in;
    logic [31:0] jump_addr_in;
    logic        ex_load_in;
    logic [4:0]  ex_rd_addr_in;
    logic [4:0]  rs1_addr_in;
    logic [4:0]  rs2_addr_in;
    logic        bus_req_in;
    logic        bus_ack_in;
    logic        pc_hold_out;
    logic        if_id_hold_out;
    logic        if_id_flush_out;
    logic        id_ex_hold_out;
    logic        id_ex_flush_out;
    logic        pc_jump_en_out;
    logic [31:0] pc_jump_addr_out;
    logic        boot_busy_out;
    logic        bus_err_out;
    logic [31:0] stall_cnt_out;
    logic [31:0] flush_cnt_out;

    modport master (
        output jump_en_in, jump_addr_in, ex_load_in, ex_rd_addr_in, rs1_addr_in, rs2_addr_in,
               bus_req_in, bus_ack_in,
        input  pc_hold_out, if_id_hold_out, if_id_flush_out, id_ex_hold_out, id_ex_flush_out,
               pc_jump_en_out, pc_jump_addr_out, boot_busy_out, bus_err_out, stall_cnt_out,
               flush_cnt_out
    );

    modport slave (
        input  jump_en_in, jump_addr_in, ex_load_in, ex_rd_addr_in, rs1_addr_in, rs2_addr_in,
               bus_req_in, bus_ack_in,
        output pc_hold_out, if_id_hold_out, if_id_flush_out, id_ex_hold_out, id_ex_flush_out,
               pc_jump_en_out, pc_jump_addr_out, boot_busy_out, bus_err_out, stall_cnt_out,
               flush_cnt_out
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: boot hold, load-use stalls, data-bus wait with timeout,
// and jump redirect with multi-cycle if_id flush. Controls are combinational from state.
module pipe_ctrl #(
    parameter int unsigned BOOT_CYCLES  = 4,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned BUS_TIMEOUT  = 16
) (
    input logic        clk,
    input logic        rst_n,
    pipe_ctrl_if.slave ctrl
);
    localparam int unsigned BootW  = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int unsigned FlushW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int unsigned TmoW   = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam logic [BootW-1:0]  BootLast  = BootW'(BOOT_CYCLES - 1);
    localparam logic [FlushW-1:0] FlushLoad = FlushW'(FLUSH_CYCLES);
    localparam logic [TmoW-1:0]   TmoMax    = TmoW'(BUS_TIMEOUT);
    localparam logic [31:0]       CntMax    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {StBoot, StRun, StBusWait, StFlush} state_e;

    state_e             state_q, ctx_q, ctx;
    logic [BootW-1:0]   boot_cnt_q;
    logic [FlushW-1:0]  fl_left_q;
    logic [TmoW-1:0]    tmo_cnt_q;
    logic [31:0]        jump_addr_q;
    logic               bus_err_q;
    logic [31:0]        stall_cnt_q;
    logic [31:0]        flush_cnt_q;

    logic boot, bus_stall, timeout, hold_bus, take_jump, load_use, in_flush, rd_match;

    always_comb begin
        boot      = (state_q == StBoot);
        bus_stall = ctrl.bus_req_in && !ctrl.bus_ack_in;
        timeout   = (state_q == StBusWait) && bus_stall && (tmo_cnt_q == TmoMax);
        // While waiting, behave as the interrupted context once the wait ends; a timeout drops to RUN.
        ctx       = state_q;
        if (state_q == StBusWait) ctx = timeout ? StRun : ctx_q;
        hold_bus  = !boot && bus_stall && !timeout;
        take_jump = !boot && !hold_bus && ctrl.jump_en_in;
        rd_match  = (ctrl.ex_rd_addr_in != 5'd0) &&
                    (((ctrl.rs1_addr_in != 5'd0) && (ctrl.rs1_addr_in == ctrl.ex_rd_addr_in)) ||
                     ((ctrl.rs2_addr_in != 5'd0) && (ctrl.rs2_addr_in == ctrl.ex_rd_addr_in)));
        load_use  = !boot && !hold_bus && !ctrl.jump_en_in && (ctx == StRun) &&
                    ctrl.ex_load_in && rd_match;
        in_flush  = !boot && !hold_bus && (ctx == StFlush);
    end

    assign ctrl.pc_hold_out      = boot || hold_bus || load_use;
    assign ctrl.if_id_hold_out   = hold_bus || load_use;
    assign ctrl.if_id_flush_out  = boot || take_jump || in_flush;
    assign ctrl.id_ex_hold_out   = hold_bus;
    assign ctrl.id_ex_flush_out  = boot || take_jump || load_use;
    assign ctrl.pc_jump_en_out   = take_jump;
    assign ctrl.pc_jump_addr_out = boot ? 32'd0 : (take_jump ? ctrl.jump_addr_in : jump_addr_q);
    assign ctrl.boot_busy_out    = boot;
    assign ctrl.bus_err_out      = bus_err_q;
    assign ctrl.stall_cnt_out    = stall_cnt_q;
    assign ctrl.flush_cnt_out    = flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StBoot;
            ctx_q       <= StRun;
            boot_cnt_q  <= '0;
            fl_left_q   <= '0;
            tmo_cnt_q   <= '0;
            jump_addr_q <= '0;
            bus_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((hold_bus || load_use) && (stall_cnt_q != CntMax)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (take_jump) begin
                jump_addr_q <= ctrl.jump_addr_in;
                if (flush_cnt_q != CntMax) flush_cnt_q <= flush_cnt_q + 32'd1;
            end
            if (timeout) bus_err_q <= 1'b1;

            if (boot) begin
                if (boot_cnt_q == BootLast) state_q <= StRun;
                else boot_cnt_q <= boot_cnt_q + BootW'(1);
            end else if (hold_bus) begin
                if (state_q != StBusWait) begin
                    ctx_q     <= state_q;
                    tmo_cnt_q <= TmoW'(1);
                    state_q   <= StBusWait;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                end
            end else begin
                tmo_cnt_q <= '0;
                if (take_jump) begin
                    fl_left_q <= FlushLoad;
                    state_q   <= (FLUSH_CYCLES == 0) ? StRun : StFlush;
                end else if (ctx == StFlush) begin
                    if (fl_left_q <= FlushW'(1)) begin
                        fl_left_q <= '0;
                        state_q   <= StRun;
                    end else begin
                        fl_left_q <= fl_left_q - FlushW'(1);
                        state_q   <= StFlush;
                    end
                end else begin
                    state_q <= StRun;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: table of per-cycle stimulus with expected controls, pushed to a scoreboard
// when driven and compared mid-cycle, plus hand-written bus-timeout and mid-flush reset sequences.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if ifc ();
    pipe_ctrl dut (.clk(clk), .rst_n(rst_n), .ctrl(ifc.slave));

    // ctl bits: {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, pc_jump_en, boot_busy}
    localparam logic [6:0] CBoot = 7'b1010101;
    localparam logic [6:0] CIdle = 7'b0000000;
    localparam logic [6:0] CLu   = 7'b1100100;
    localparam logic [6:0] CJmp  = 7'b0010110;
    localparam logic [6:0] CFl   = 7'b0010000;
    localparam logic [6:0] CBus  = 7'b1101000;

    typedef struct {
        string       name;
        bit          rst;
        bit          jmp;
        logic [31:0] addr;
        bit          ld;
        logic [4:0]  rd, rs1, rs2;
        bit          req, ack;
        logic [6:0]  ctl;
        bit          tmo;
    } vec_t;

    typedef struct {
        string       name;
        logic [6:0]  ctl;
        logic [31:0] addr;
        logic        err;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    vec_t        tbl[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_addr = 0, m_stall = 0, m_flush = 0;
    logic        m_err = 0;

    function automatic vec_t mk(string nm, bit jmp, logic [31:0] addr, bit ld, logic [4:0] rd,
                                logic [4:0] rs1, logic [4:0] rs2, bit req, bit ack, logic [6:0] ctl);
        vec_t v;
        v.name = nm; v.rst = 0; v.jmp = jmp; v.addr = addr; v.ld = ld; v.rd = rd; v.rs1 = rs1;
        v.rs2 = rs2; v.req = req; v.ack = ack; v.ctl = ctl; v.tmo = 0;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t x;
        @(posedge clk);
        #1;
        if (v.rst) begin
            m_addr = 0; m_stall = 0; m_flush = 0; m_err = 0;
        end
        rst_n             = !v.rst;
        ifc.jump_en_in    = v.jmp;
        ifc.jump_addr_in  = v.addr;
        ifc.ex_load_in    = v.ld;
        ifc.ex_rd_addr_in = v.rd;
        ifc.rs1_addr_in   = v.rs1;
        ifc.rs2_addr_in   = v.rs2;
        ifc.bus_req_in    = v.req;
        ifc.bus_ack_in    = v.ack;
        x.name  = v.name;
        x.ctl   = v.ctl;
        x.addr  = v.ctl[1] ? v.addr : m_addr;
        x.err   = m_err;
        x.stall = m_stall;
        x.flush = m_flush;
        sb.push_back(x);
        // Counters and the error flag are registered: this cycle's events show up next cycle.
        if (v.ctl[1]) begin
            m_addr  = v.addr;
            m_flush = m_flush + 1;
        end
        if (v.ctl[5]) m_stall = m_stall + 1;
        if (v.tmo) m_err = 1'b1;
    endtask

    task automatic chk(input string nm, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", nm, what, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, "ctl", {25'd0, ifc.pc_hold_out, ifc.if_id_hold_out, ifc.if_id_flush_out,
                                ifc.id_ex_hold_out, ifc.id_ex_flush_out, ifc.pc_jump_en_out,
                                ifc.boot_busy_out}, {25'd0, e.ctl});
            chk(e.name, "addr", ifc.pc_jump_addr_out, e.addr);
            chk(e.name, "err", {31'd0, ifc.bus_err_out}, {31'd0, e.err});
            chk(e.name, "stall_cnt", ifc.stall_cnt_out, e.stall);
            chk(e.name, "flush_cnt", ifc.flush_cnt_out, e.flush);
        end
    end

    initial begin
        vec_t v;
        ifc.jump_en_in = 0; ifc.jump_addr_in = 0; ifc.ex_load_in = 0; ifc.ex_rd_addr_in = 0;
        ifc.rs1_addr_in = 0; ifc.rs2_addr_in = 0; ifc.bus_req_in = 0; ifc.bus_ack_in = 0;

        tbl.push_back(mk("boot0",        0, 0,       0, 0, 0, 0, 0, 0, CBoot));
        tbl.push_back(mk("boot1",        0, 0,       1, 5, 0, 5, 1, 0, CBoot));
        tbl.push_back(mk("boot2_jmp",    1, 'hDEAD,  0, 0, 0, 0, 0, 0, CBoot));
        tbl.push_back(mk("boot3",        0, 0,       0, 0, 0, 0, 0, 0, CBoot));
        tbl.push_back(mk("run_idle",     0, 0,       0, 0, 0, 0, 0, 0, CIdle));
        tbl.push_back(mk("lu_rs2",       0, 0,       1, 5, 3, 5, 0, 0, CLu));
        tbl.push_back(mk("after_lu",     0, 0,       0, 5, 3, 5, 0, 0, CIdle));
        tbl.push_back(mk("load_x0",      0, 0,       1, 0, 0, 0, 0, 0, CIdle));
        tbl.push_back(mk("lu_rs1",       0, 0,       1, 7, 7, 0, 0, 0, CLu));
        tbl.push_back(mk("load_nomatch", 0, 0,       1, 7, 6, 8, 0, 0, CIdle));
        tbl.push_back(mk("no_load",      0, 0,       0, 7, 7, 7, 0, 0, CIdle));
        tbl.push_back(mk("jump",         1, 'h100,   0, 0, 0, 0, 0, 0, CJmp));
        tbl.push_back(mk("flush",        0, 0,       0, 0, 0, 0, 0, 0, CFl));
        tbl.push_back(mk("run_after_fl", 0, 0,       0, 0, 0, 0, 0, 0, CIdle));
        tbl.push_back(mk("jump_over_lu", 1, 'h200,   1, 5, 0, 5, 0, 0, CJmp));
        tbl.push_back(mk("flush_no_lu",  0, 0,       1, 5, 0, 5, 0, 0, CFl));
        tbl.push_back(mk("jump3",        1, 'h300,   0, 0, 0, 0, 0, 0, CJmp));
        tbl.push_back(mk("jump_in_fl",   1, 'h340,   0, 0, 0, 0, 0, 0, CJmp));
        tbl.push_back(mk("flush2",       0, 0,       0, 0, 0, 0, 0, 0, CFl));
        tbl.push_back(mk("idle2",        0, 0,       0, 0, 0, 0, 0, 0, CIdle));
        tbl.push_back(mk("bus_jmp_w0",   1, 'h400,   0, 0, 0, 0, 1, 0, CBus));
        tbl.push_back(mk("bus_jmp_w1",   1, 'h400,   0, 0, 0, 0, 1, 0, CBus));
        tbl.push_back(mk("bus_jmp_w2",   1, 'h400,   0, 0, 0, 0, 1, 0, CBus));
        tbl.push_back(mk("bus_ack_jmp",  1, 'h400,   0, 0, 0, 0, 1, 1, CJmp));
        tbl.push_back(mk("flush_ack",    0, 0,       0, 0, 0, 0, 0, 0, CFl));
        tbl.push_back(mk("idle3",        0, 0,       0, 0, 0, 0, 0, 0, CIdle));
        tbl.push_back(mk("jump5",        1, 'h500,   0, 0, 0, 0, 0, 0, CJmp));
        tbl.push_back(mk("bus_in_fl",    0, 0,       0, 0, 0, 0, 1, 0, CBus));
        tbl.push_back(mk("ack_to_fl",    0, 0,       0, 0, 0, 0, 1, 1, CFl));
        tbl.push_back(mk("idle4",        0, 0,       0, 0, 0, 0, 0, 0, CIdle));
        tbl.push_back(mk("bus_w",        0, 0,       0, 0, 0, 0, 1, 0, CBus));
        tbl.push_back(mk("req_drop",     0, 0,       0, 0, 0, 0, 0, 0, CIdle));
        tbl.push_back(mk("idle5",        0, 0,       0, 0, 0, 0, 0, 0, CIdle));

        // Held in reset with inputs active: boot outputs, inputs ignored.
        repeat (2) @(posedge clk);
        v = mk("in_reset", 1, 'h80, 1, 5, 5, 5, 1, 0, CBoot);
        v.rst = 1;
        apply(v);

        foreach (tbl[i]) apply(tbl[i]);

        // Bus timeout: 16 hold cycles, then release with the error flag set next cycle.
        for (int k = 0; k < 16; k++) apply(mk("tmo_hold", 0, 0, 0, 0, 0, 0, 1, 0, CBus));
        v = mk("tmo_release", 0, 0, 0, 0, 0, 0, 1, 0, CIdle);
        v.tmo = 1;
        apply(v);
        apply(mk("after_tmo", 0, 0, 0, 0, 0, 0, 0, 0, CIdle));
        apply(mk("jump6", 1, 'h600, 0, 0, 0, 0, 0, 0, CJmp));

        // Reset lands in the FLUSH cycle: boot outputs at once, error and counters cleared.
        v = mk("rst_mid_flush", 0, 0, 0, 0, 0, 0, 0, 0, CBoot);
        v.rst = 1;
        apply(v);
        v.name = "rst_hold";
        apply(v);

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
